// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the iterative MIPS multiply/divide unit.
package muldiv_sequencer_pkg;

    // Instruction sub-opcode as presented by the EX stage.
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath.
// The accumulator's low half holds the multiplier (shifted out at the right)
// or the dividend/quotient (shifted out at the left, quotient bits in from the right).
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] trial;

    // Shift-add for multiply, restoring trial-subtract for divide.
    always_comb begin
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        // Remainder shifted left by one keeps the bit that falls out of the top,
        // so the trial works on WIDTH+1 bits and the borrow is the top bit.
        trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        if (div_mode) begin
            if (trial[WIDTH]) begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_next = {add_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with private HI/LO registers.
// Works on magnitudes for WIDTH cycles, then applies sign correction in one
// FIX cycle and writes HI/LO. Stalls the pipeline while an op is in flight
// and the EX/ID stages want HI/LO or want to start another op.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hilo_read,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e             state_reg;
    logic [1:0]         op_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   opnd_reg;
    logic               sign_a_reg;
    logic               sign_b_reg;
    logic [CW-1:0]      count_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               busy_reg;
    logic               done_reg;

    logic               in_signed;
    logic               in_div;
    logic [WIDTH-1:0]   mag_rs;
    logic [WIDTH-1:0]   mag_rt;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_next_src()),
        .operand  (opnd_reg),
        .div_mode (is_div_op(op_reg)),
        .acc_next (acc_next)
    );

    function automatic logic [2*WIDTH-1:0] acc_next_src();
        return acc_reg;
    endfunction

    // Operand magnitudes at op entry; the most negative value negates to
    // itself, which read as unsigned is exactly 2^(WIDTH-1).
    always_comb begin
        in_signed = is_signed_op(op);
        in_div    = is_div_op(op);
        mag_rs    = (in_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
        mag_rt    = (in_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;
    end

    // Sign correction applied during FIX. Sign flags are only ever set for
    // signed ops, so unsigned results pass straight through.
    // A zero divisor leaves remainder == |dividend|, which after sign
    // restoration is the raw dividend; only the quotient needs overriding.
    always_comb begin
        prod_fix = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
        quot_fix = (sign_a_reg ^ sign_b_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
        rem_fix  = sign_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
        if (opnd_reg == '0) begin
            quot_fix = '1;
        end
    end

    // Sequencer FSM, iteration counter and HI/LO registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg  <= S_IDLE;
            op_reg     <= 2'b00;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            count_reg  <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        // Start wins over a same-cycle MTHI/MTLO.
                        state_reg  <= S_RUN;
                        busy_reg   <= 1'b1;
                        op_reg     <= op;
                        count_reg  <= CW'(WIDTH);
                        sign_a_reg <= in_signed & rs_val[WIDTH-1];
                        sign_b_reg <= in_signed & rt_val[WIDTH-1];
                        if (in_div) begin
                            acc_reg  <= {{WIDTH{1'b0}}, mag_rs};
                            opnd_reg <= mag_rt;
                        end else begin
                            acc_reg  <= {{WIDTH{1'b0}}, mag_rt};
                            opnd_reg <= mag_rs;
                        end
                    end else begin
                        state_reg <= S_IDLE;
                        if (hi_wr) begin
                            hi_reg <= wr_data;
                        end
                        if (lo_wr) begin
                            lo_reg <= wr_data;
                        end
                    end
                end
                S_RUN: begin
                    acc_reg   <= acc_next;
                    count_reg <= count_reg - CW'(1);
                    if (count_reg == CW'(1)) begin
                        state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div_op(op_reg)) begin
                        hi_reg <= rem_fix;
                        lo_reg <= quot_fix;
                    end else begin
                        hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fix[WIDTH-1:0];
                    end
                    state_reg <= S_DONE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign hi_out = hi_reg;
    assign lo_out = lo_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;
    assign stall  = busy_reg & (start | hilo_read | hi_wr | lo_wr);

endmodule
